// File: rtl/ctrl_pkg.sv
// Shared definitions for the Mini-SRC hardwired control unit.
//   - opcode constants (ir[31:27])
//   - FSM state encoding
//   - ctrl_t: the full bundle of registered control strobes driven to the Datapath
//   - is_alu_rop(): true for the two-operand register ALU instructions
package ctrl_pkg;

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_ROR  = 5'b00111;
  localparam logic [4:0] OP_ROL  = 5'b01000;
  localparam logic [4:0] OP_SHR  = 5'b01001;
  localparam logic [4:0] OP_SHL  = 5'b01011;
  localparam logic [4:0] OP_MUL  = 5'b01111;
  localparam logic [4:0] OP_DIV  = 5'b10000;
  localparam logic [4:0] OP_BR   = 5'b10010;
  localparam logic [4:0] OP_JR   = 5'b10011;
  localparam logic [4:0] OP_IN   = 5'b10110;
  localparam logic [4:0] OP_OUT  = 5'b10111;
  localparam logic [4:0] OP_MFHI = 5'b11000;
  localparam logic [4:0] OP_MFLO = 5'b11001;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  typedef enum logic [3:0] {
    S_RESET,
    T0, T1, T2, T3, T4, T5, T6, T7,
    S_DIVW,
    S_HALT
  } state_t;

  typedef struct packed {
    logic       run;
    logic [4:0] op_sel;
    logic       inc_pc;
    logic       read;
    logic       write;
    logic       gra;
    logic       grb;
    logic       grc;
    logic       rin;
    logic       r_out;
    logic       ba_out;
    logic       reset_div;
    logic       mdr_rd;
    logic       mar_rd;
    logic       hi_rd;
    logic       lo_rd;
    logic       zhi_rd;
    logic       zlo_rd;
    logic       pc_rd;
    logic       out_rd;
    logic       y_rd;
    logic       ir_rd;
    logic       mdr_out;
    logic       hi_out;
    logic       lo_out;
    logic       zhi_out;
    logic       zlo_out;
    logic       pc_out;
    logic       in_out;
    logic       c_out;
  } ctrl_t;

  function automatic logic is_alu_rop(input logic [4:0] opc);
    return (opc == OP_ADD) || (opc == OP_SUB) || (opc == OP_AND) || (opc == OP_OR) ||
           (opc == OP_SHR) || (opc == OP_SHL) || (opc == OP_ROR) || (opc == OP_ROL);
  endfunction

endpackage

// File: rtl/control_unit.sv
// control_unit: hardwired Moore FSM sequencing the Mini-SRC Datapath
// (fetch -> decode -> execute). Every strobe is a registered decode of the
// next state, so outputs line up with state_q and there is no
// combinational path from ir/con_ff to any output.
//
// Ports
//   clk            clock, all updates on posedge
//   clr            synchronous active-high reset (also the Datapath clr)
//   ir[31:0]       IR contents from the Datapath; only ir[31:27] is decoded
//   con_ff         branch condition, captured while in T3
//   calc_finished  divider done (used only with CTRL_DIV_HANDSHAKE_EN)
//   stop           level; diverts the next T0 entry into S_HALT
//   run            1 while executing, 0 in S_RESET / S_HALT
//   op_sel[4:0]    ALU operation
//   remaining 1-bit outputs are Datapath register strobes / bus drivers
//
// Build option
//   CTRL_DIV_HANDSHAKE_EN defined   : S_DIVW leaves when calc_finished=1
//   CTRL_DIV_HANDSHAKE_EN undefined : S_DIVW lasts DIV_CYCLES cycles (6-bit down-counter)
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_RESET | held by clr, all strobes low
// T0      | PC -> MAR, PC++ (or S_HALT if stop)
// T1      | memory read into MDR
// T2      | MDR -> IR
// T3      | decode / first execute step
// T4..T6  | execute steps, meaning depends on opcode
// T7      | ld/st final step; div result capture into Z (then T5)
// S_DIVW  | divider running, operands held on the bus
// S_HALT  | stopped, left only by clr
module control_unit
  import ctrl_pkg::*;
#(
  parameter int DIV_CYCLES = 34
) (
  input  logic        clk,
  input  logic        clr,
  input  logic [31:0] ir,
  input  logic        con_ff,
  input  logic        calc_finished,
  input  logic        stop,
  output logic        run,
  output logic [4:0]  op_sel,
  output logic        IncPC,
  output logic        Read,
  output logic        Write,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        Rin,
  output logic        R_out,
  output logic        BAout,
  output logic        reset_div,
  output logic        MDR_rd,
  output logic        MAR_rd,
  output logic        HI_rd,
  output logic        LO_rd,
  output logic        Zhi_rd,
  output logic        Zlo_rd,
  output logic        PC_rd,
  output logic        Out_rd,
  output logic        Y_rd,
  output logic        IR_rd,
  output logic        MDR_out,
  output logic        HI_out,
  output logic        LO_out,
  output logic        Zhi_out,
  output logic        Zlo_out,
  output logic        PC_out,
  output logic        In_out,
  output logic        C_out
);

  state_t     state_q, state_d, t0_next;
  ctrl_t      ctl_q, ctl_d;
  logic       cond_q;
  logic       div_done;
  logic [4:0] opc;

  assign opc = ir[31:27];

`ifdef CTRL_DIV_HANDSHAKE_EN
  logic unused_in;
  assign unused_in = ^ir[26:0];
  assign div_done  = calc_finished;
`else
  localparam logic [5:0] DIV_LOAD = 6'(DIV_CYCLES - 1);
  logic       unused_in;
  logic [5:0] div_cnt_q, div_cnt_d;

  assign unused_in = ^{calc_finished, ir[26:0]};

  // Loaded while in T4 so the first S_DIVW cycle sees DIV_CYCLES-1;
  // terminal count 0 marks the last wait cycle.
  always_comb begin
    div_cnt_d = div_cnt_q;
    if (state_q == T4)
      div_cnt_d = DIV_LOAD;
    else if (state_q == S_DIVW && div_cnt_q != 6'd0)
      div_cnt_d = div_cnt_q - 6'd1;
  end

  always_ff @(posedge clk) begin
    if (clr) div_cnt_q <= 6'd0;
    else     div_cnt_q <= div_cnt_d;
  end

  assign div_done = (div_cnt_q == 6'd0);
`endif

  function automatic ctrl_t decode(input state_t s, input logic [4:0] op, input logic cond);
    ctrl_t c;
    c     = '0;
    c.run = (s != S_RESET) && (s != S_HALT);
    case (s)
      T0: begin c.pc_out = 1'b1; c.mar_rd = 1'b1; c.inc_pc = 1'b1; end
      T1: begin c.read = 1'b1; c.mdr_rd = 1'b1; end
      T2: begin c.mdr_out = 1'b1; c.ir_rd = 1'b1; end
      T3: begin
        if (is_alu_rop(op)) begin
          c.grb = 1'b1; c.r_out = 1'b1; c.y_rd = 1'b1;
        end else begin
          case (op)
            OP_LDI, OP_LD, OP_ST: begin
              c.grb = 1'b1; c.ba_out = 1'b1; c.r_out = 1'b1; c.y_rd = 1'b1;
            end
            OP_MUL, OP_DIV: begin c.gra = 1'b1; c.r_out = 1'b1; c.y_rd = 1'b1; end
            OP_BR:   begin c.gra = 1'b1; c.r_out = 1'b1; end
            OP_JR:   begin c.gra = 1'b1; c.r_out = 1'b1; c.pc_rd = 1'b1; end
            OP_MFHI: begin c.hi_out = 1'b1; c.gra = 1'b1; c.rin = 1'b1; end
            OP_MFLO: begin c.lo_out = 1'b1; c.gra = 1'b1; c.rin = 1'b1; end
            OP_IN:   begin c.in_out = 1'b1; c.gra = 1'b1; c.rin = 1'b1; end
            OP_OUT:  begin c.gra = 1'b1; c.r_out = 1'b1; c.out_rd = 1'b1; end
            OP_NOP, OP_HALT: ;
            default: ;
          endcase
        end
      end
      T4: begin
        if (is_alu_rop(op)) begin
          c.grc = 1'b1; c.r_out = 1'b1; c.zlo_rd = 1'b1; c.op_sel = op;
        end else begin
          case (op)
            OP_LDI, OP_LD, OP_ST: begin c.c_out = 1'b1; c.op_sel = OP_ADD; c.zlo_rd = 1'b1; end
            OP_MUL: begin
              c.grb = 1'b1; c.r_out = 1'b1; c.op_sel = OP_MUL; c.zhi_rd = 1'b1; c.zlo_rd = 1'b1;
            end
            OP_DIV:  c.reset_div = 1'b1;
            OP_BR:   begin c.pc_out = 1'b1; c.y_rd = 1'b1; end
            default: ;
          endcase
        end
      end
      T5: begin
        if (is_alu_rop(op) || op == OP_LDI) begin
          c.zlo_out = 1'b1; c.gra = 1'b1; c.rin = 1'b1;
        end else begin
          case (op)
            OP_LD, OP_ST:   begin c.zlo_out = 1'b1; c.mar_rd = 1'b1; end
            OP_MUL, OP_DIV: begin c.zlo_out = 1'b1; c.lo_rd = 1'b1; end
            OP_BR:   begin c.c_out = 1'b1; c.op_sel = OP_ADD; c.zlo_rd = 1'b1; end
            default: ;
          endcase
        end
      end
      T6: begin
        case (op)
          OP_LD:          begin c.read = 1'b1; c.mdr_rd = 1'b1; end
          OP_ST:          begin c.gra = 1'b1; c.r_out = 1'b1; c.mdr_rd = 1'b1; end
          OP_MUL, OP_DIV: begin c.zhi_out = 1'b1; c.hi_rd = 1'b1; end
          OP_BR:          if (cond) begin c.zlo_out = 1'b1; c.pc_rd = 1'b1; end
          default: ;
        endcase
      end
      T7: begin
        case (op)
          OP_LD: begin c.mdr_out = 1'b1; c.gra = 1'b1; c.rin = 1'b1; end
          OP_ST: c.write = 1'b1;
          // keep the divider operands on the bus while Z captures the result
          OP_DIV: begin
            c.grb = 1'b1; c.r_out = 1'b1; c.op_sel = OP_DIV; c.zhi_rd = 1'b1; c.zlo_rd = 1'b1;
          end
          default: ;
        endcase
      end
      S_DIVW: begin c.grb = 1'b1; c.r_out = 1'b1; c.op_sel = OP_DIV; end
      default: ;
    endcase
    return c;
  endfunction

  always_comb begin
    t0_next = stop ? S_HALT : T0;
    state_d = state_q;
    case (state_q)
      S_RESET: state_d = t0_next;
      T0:      state_d = T1;
      T1:      state_d = T2;
      T2:      state_d = T3;
      T3: begin
        if (opc == OP_HALT)
          state_d = S_HALT;
        else if (is_alu_rop(opc) || opc == OP_LDI || opc == OP_LD || opc == OP_ST ||
                 opc == OP_MUL || opc == OP_DIV || opc == OP_BR)
          state_d = T4;
        else
          state_d = t0_next;
      end
      T4: state_d = (opc == OP_DIV) ? S_DIVW : T5;
      T5: begin
        if (opc == OP_LD || opc == OP_ST || opc == OP_MUL || opc == OP_DIV || opc == OP_BR)
          state_d = T6;
        else
          state_d = t0_next;
      end
      T6:      state_d = (opc == OP_LD || opc == OP_ST) ? T7 : t0_next;
      T7:      state_d = (opc == OP_DIV) ? T5 : t0_next;
      S_DIVW:  if (div_done) state_d = T7;
      S_HALT:  state_d = S_HALT;
      default: state_d = S_RESET;
    endcase
    ctl_d = decode(state_d, opc, cond_q);
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= S_RESET;
      ctl_q   <= '0;
      cond_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ctl_q   <= ctl_d;
      if (state_q == T3) cond_q <= con_ff;
    end
  end

  assign run       = ctl_q.run;
  assign op_sel    = ctl_q.op_sel;
  assign IncPC     = ctl_q.inc_pc;
  assign Read      = ctl_q.read;
  assign Write     = ctl_q.write;
  assign Gra       = ctl_q.gra;
  assign Grb       = ctl_q.grb;
  assign Grc       = ctl_q.grc;
  assign Rin       = ctl_q.rin;
  assign R_out     = ctl_q.r_out;
  assign BAout     = ctl_q.ba_out;
  assign reset_div = ctl_q.reset_div;
  assign MDR_rd    = ctl_q.mdr_rd;
  assign MAR_rd    = ctl_q.mar_rd;
  assign HI_rd     = ctl_q.hi_rd;
  assign LO_rd     = ctl_q.lo_rd;
  assign Zhi_rd    = ctl_q.zhi_rd;
  assign Zlo_rd    = ctl_q.zlo_rd;
  assign PC_rd     = ctl_q.pc_rd;
  assign Out_rd    = ctl_q.out_rd;
  assign Y_rd      = ctl_q.y_rd;
  assign IR_rd     = ctl_q.ir_rd;
  assign MDR_out   = ctl_q.mdr_out;
  assign HI_out    = ctl_q.hi_out;
  assign LO_out    = ctl_q.lo_out;
  assign Zhi_out   = ctl_q.zhi_out;
  assign Zlo_out   = ctl_q.zlo_out;
  assign PC_out    = ctl_q.pc_out;
  assign In_out    = ctl_q.in_out;
  assign C_out     = ctl_q.c_out;

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: per-instruction strobe sequences,
// branch condition capture, clr abort, divider wait length, halt/stop.
module tb_control_unit;

  logic        clk = 1'b0;
  logic        clr = 1'b1;
  logic [31:0] ir = 32'h0;
  logic        con_ff = 1'b0;
  logic        calc_finished = 1'b0;
  logic        stop = 1'b0;
  logic        run;
  logic [4:0]  op_sel;
  logic IncPC, Read, Write, Gra, Grb, Grc, Rin, R_out, BAout, reset_div;
  logic MDR_rd, MAR_rd, HI_rd, LO_rd, Zhi_rd, Zlo_rd, PC_rd, Out_rd, Y_rd, IR_rd;
  logic MDR_out, HI_out, LO_out, Zhi_out, Zlo_out, PC_out, In_out, C_out;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  control_unit dut (
    .clk(clk), .clr(clr), .ir(ir), .con_ff(con_ff), .calc_finished(calc_finished),
    .stop(stop), .run(run), .op_sel(op_sel), .IncPC(IncPC), .Read(Read), .Write(Write),
    .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .R_out(R_out), .BAout(BAout),
    .reset_div(reset_div), .MDR_rd(MDR_rd), .MAR_rd(MAR_rd), .HI_rd(HI_rd), .LO_rd(LO_rd),
    .Zhi_rd(Zhi_rd), .Zlo_rd(Zlo_rd), .PC_rd(PC_rd), .Out_rd(Out_rd), .Y_rd(Y_rd),
    .IR_rd(IR_rd), .MDR_out(MDR_out), .HI_out(HI_out), .LO_out(LO_out), .Zhi_out(Zhi_out),
    .Zlo_out(Zlo_out), .PC_out(PC_out), .In_out(In_out), .C_out(C_out)
  );

  logic [33:0] outs;
  assign outs = {run, op_sel, IncPC, Read, Write, Gra, Grb, Grc, Rin, R_out, BAout, reset_div,
                 MDR_rd, MAR_rd, HI_rd, LO_rd, Zhi_rd, Zlo_rd, PC_rd, Out_rd, Y_rd, IR_rd,
                 MDR_out, HI_out, LO_out, Zhi_out, Zlo_out, PC_out, In_out, C_out};

  localparam logic [33:0] M_RUN     = 34'd1 << 33;
  localparam logic [33:0] M_INCPC   = 34'd1 << 27;
  localparam logic [33:0] M_READ    = 34'd1 << 26;
  localparam logic [33:0] M_WRITE   = 34'd1 << 25;
  localparam logic [33:0] M_GRA     = 34'd1 << 24;
  localparam logic [33:0] M_GRB     = 34'd1 << 23;
  localparam logic [33:0] M_GRC     = 34'd1 << 22;
  localparam logic [33:0] M_RIN     = 34'd1 << 21;
  localparam logic [33:0] M_R_OUT   = 34'd1 << 20;
  localparam logic [33:0] M_BAOUT   = 34'd1 << 19;
  localparam logic [33:0] M_RST_DIV = 34'd1 << 18;
  localparam logic [33:0] M_MDR_RD  = 34'd1 << 17;
  localparam logic [33:0] M_MAR_RD  = 34'd1 << 16;
  localparam logic [33:0] M_HI_RD   = 34'd1 << 15;
  localparam logic [33:0] M_LO_RD   = 34'd1 << 14;
  localparam logic [33:0] M_ZHI_RD  = 34'd1 << 13;
  localparam logic [33:0] M_ZLO_RD  = 34'd1 << 12;
  localparam logic [33:0] M_PC_RD   = 34'd1 << 11;
  localparam logic [33:0] M_OUT_RD  = 34'd1 << 10;
  localparam logic [33:0] M_Y_RD    = 34'd1 << 9;
  localparam logic [33:0] M_IR_RD   = 34'd1 << 8;
  localparam logic [33:0] M_MDR_OUT = 34'd1 << 7;
  localparam logic [33:0] M_HI_OUT  = 34'd1 << 6;
  localparam logic [33:0] M_LO_OUT  = 34'd1 << 5;
  localparam logic [33:0] M_ZHI_OUT = 34'd1 << 4;
  localparam logic [33:0] M_ZLO_OUT = 34'd1 << 3;
  localparam logic [33:0] M_PC_OUT  = 34'd1 << 2;
  localparam logic [33:0] M_IN_OUT  = 34'd1 << 1;
  localparam logic [33:0] M_C_OUT   = 34'd1 << 0;

  localparam logic [33:0] OPS_ADD = {1'b0, 5'b00011, 28'd0};
  localparam logic [33:0] OPS_MUL = {1'b0, 5'b01111, 28'd0};
  localparam logic [33:0] OPS_DIV = {1'b0, 5'b10000, 28'd0};

  localparam logic [33:0] F0 = M_RUN | M_PC_OUT | M_MAR_RD | M_INCPC;
  localparam logic [33:0] F1 = M_RUN | M_READ | M_MDR_RD;
  localparam logic [33:0] F2 = M_RUN | M_MDR_OUT | M_IR_RD;
  localparam logic [33:0] IMM_T3 = M_RUN | M_GRB | M_BAOUT | M_R_OUT | M_Y_RD;
  localparam logic [33:0] IMM_T4 = M_RUN | M_C_OUT | OPS_ADD | M_ZLO_RD;
  localparam logic [33:0] WB_T5  = M_RUN | M_ZLO_OUT | M_GRA | M_RIN;
  localparam logic [33:0] MD_T3  = M_RUN | M_GRA | M_R_OUT | M_Y_RD;
  localparam logic [33:0] MD_T5  = M_RUN | M_ZLO_OUT | M_LO_RD;
  localparam logic [33:0] MD_T6  = M_RUN | M_ZHI_OUT | M_HI_RD;
  localparam logic [33:0] DIV_W  = M_RUN | M_GRB | M_R_OUT | OPS_DIV;

`ifdef CTRL_DIV_HANDSHAKE_EN
  localparam int EXP_WAIT = 10;
`else
  localparam int EXP_WAIT = 34;
`endif

  // Leaves the bench at the negedge where the DUT sits in T0.
  task automatic start(input logic [31:0] instr);
    ir   = instr;
    stop = 1'b0;
    clr  = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset;
    clr = 1'b1;
    repeat (3) @(negedge clk);
    n_chk++;
    if (outs !== 34'd0) $display("FAIL reset_outputs: got %h want %h", outs, 34'd0);
    else n_pass++;
    clr = 1'b0;
    @(negedge clk);
    n_chk++;
    if (outs !== F0) $display("FAIL reset_to_t0: got %h want %h", outs, F0);
    else n_pass++;
  endtask

  task automatic test_add;
    logic [33:0] ev[$];
    ev = '{F0, F1, F2, M_RUN | M_GRB | M_R_OUT | M_Y_RD,
           M_RUN | M_GRC | M_R_OUT | M_ZLO_RD | OPS_ADD, WB_T5, F0};
    start(32'h1891_8000);
    for (int i = 0; i < ev.size(); i++) begin
      n_chk++;
      if (outs !== ev[i]) $display("FAIL add step %0d: got %h want %h", i, outs, ev[i]);
      else n_pass++;
      @(negedge clk);
    end
  endtask

  task automatic test_ld_clr;
    logic [33:0] ev[$];
    ev = '{F0, F1, F2, IMM_T3, IMM_T4, M_RUN | M_ZLO_OUT | M_MAR_RD};
    start(32'h0080_0005);
    for (int i = 0; i < ev.size(); i++) begin
      n_chk++;
      if (outs !== ev[i]) $display("FAIL ld step %0d: got %h want %h", i, outs, ev[i]);
      else n_pass++;
      @(negedge clk);
    end
    n_chk++;
    if (outs !== (M_RUN | M_READ | M_MDR_RD))
      $display("FAIL ld t6: got %h want %h", outs, M_RUN | M_READ | M_MDR_RD);
    else n_pass++;
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    n_chk++;
    if (outs !== 34'd0) $display("FAIL ld_clr abort: got %h want %h", outs, 34'd0);
    else n_pass++;
    @(negedge clk);
    n_chk++;
    if (outs !== F0) $display("FAIL ld_clr restart: got %h want %h", outs, F0);
    else n_pass++;
  endtask

  task automatic test_st;
    logic [33:0] ev[$];
    ev = '{F0, F1, F2, IMM_T3, IMM_T4, M_RUN | M_ZLO_OUT | M_MAR_RD,
           M_RUN | M_GRA | M_R_OUT | M_MDR_RD, M_RUN | M_WRITE, F0, F1};
    start(32'h1000_0000);
    for (int i = 0; i < ev.size(); i++) begin
      n_chk++;
      if (outs !== ev[i]) $display("FAIL st step %0d: got %h want %h", i, outs, ev[i]);
      else n_pass++;
      @(negedge clk);
    end
  endtask

  task automatic test_br(input logic cond);
    logic [33:0] ev[$];
    ev = '{F0, F1, F2, M_RUN | M_GRA | M_R_OUT, M_RUN | M_PC_OUT | M_Y_RD,
           M_RUN | M_C_OUT | OPS_ADD | M_ZLO_RD,
           cond ? (M_RUN | M_ZLO_OUT | M_PC_RD) : M_RUN, F0};
    con_ff = cond;
    start(32'h9000_0000);
    for (int i = 0; i < ev.size(); i++) begin
      n_chk++;
      if (outs !== ev[i])
        $display("FAIL br cond=%0b step %0d: got %h want %h", cond, i, outs, ev[i]);
      else n_pass++;
      if (i == 4) con_ff = ~cond;   // condition must already be captured in T3
      @(negedge clk);
    end
    con_ff = 1'b0;
  endtask

  task automatic test_mul;
    logic [33:0] ev[$];
    ev = '{F0, F1, F2, MD_T3, M_RUN | M_GRB | M_R_OUT | OPS_MUL | M_ZHI_RD | M_ZLO_RD,
           MD_T5, MD_T6, F0};
    start(32'h7800_0000);
    for (int i = 0; i < ev.size(); i++) begin
      n_chk++;
      if (outs !== ev[i]) $display("FAIL mul step %0d: got %h want %h", i, outs, ev[i]);
      else n_pass++;
      @(negedge clk);
    end
  endtask

  task automatic test_div;
    logic [33:0] pre[$];
    logic [33:0] post[$];
    int k;
    pre  = '{F0, F1, F2, MD_T3, M_RUN | M_RST_DIV};
    post = '{DIV_W | M_ZHI_RD | M_ZLO_RD, MD_T5, MD_T6, F0};
    start(32'h8000_0000);
    for (int i = 0; i < pre.size(); i++) begin
      n_chk++;
      if (outs !== pre[i]) $display("FAIL div step %0d: got %h want %h", i, outs, pre[i]);
      else n_pass++;
      @(negedge clk);
    end
    k = 0;
    while (outs === DIV_W && k < 100) begin
      k++;
      if (k == 10) calc_finished = 1'b1;
      @(negedge clk);
    end
    calc_finished = 1'b0;
    n_chk++;
    if (k != EXP_WAIT) $display("FAIL div wait cycles: got %0d want %0d", k, EXP_WAIT);
    else n_pass++;
    for (int i = 0; i < post.size(); i++) begin
      n_chk++;
      if (outs !== post[i]) $display("FAIL div tail %0d: got %h want %h", i, outs, post[i]);
      else n_pass++;
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back;
    logic [33:0] ev[$];
    ev = '{F0, F1, F2, IMM_T3, IMM_T4, WB_T5, F0, F1, F2,
           M_RUN | M_GRA | M_R_OUT | M_PC_RD, F0};
    start(32'h0800_0000);
    for (int i = 0; i < ev.size(); i++) begin
      n_chk++;
      if (outs !== ev[i]) $display("FAIL ldi_jr step %0d: got %h want %h", i, outs, ev[i]);
      else n_pass++;
      if (i == 6) ir = 32'h9800_0000;
      @(negedge clk);
    end
  endtask

  task automatic test_undef;
    logic [33:0] ev[$];
    ev = '{F0, F1, F2, M_RUN, F0};
    start(32'hF800_0000);
    for (int i = 0; i < ev.size(); i++) begin
      n_chk++;
      if (outs !== ev[i]) $display("FAIL undef step %0d: got %h want %h", i, outs, ev[i]);
      else n_pass++;
      @(negedge clk);
    end
  endtask

  task automatic test_halt;
    logic [33:0] ev[$];
    int bad;
    ev = '{F0, F1, F2, M_RUN};
    start(32'hD800_0000);
    for (int i = 0; i < ev.size(); i++) begin
      n_chk++;
      if (outs !== ev[i]) $display("FAIL halt step %0d: got %h want %h", i, outs, ev[i]);
      else n_pass++;
      @(negedge clk);
    end
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      if (outs !== 34'd0) bad++;
      @(negedge clk);
    end
    n_chk++;
    if (bad != 0) $display("FAIL halt hold: got %0d active cycles want 0", bad);
    else n_pass++;
    start(32'hD000_0000);
    n_chk++;
    if (outs !== F0) $display("FAIL halt restart: got %h want %h", outs, F0);
    else n_pass++;
  endtask

  task automatic test_stop;
    int bad;
    start(32'hD000_0000);
    repeat (3) @(negedge clk);
    n_chk++;
    if (outs !== M_RUN) $display("FAIL stop nop_t3: got %h want %h", outs, M_RUN);
    else n_pass++;
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      if (outs !== 34'd0 || run !== 1'b0) bad++;
      @(negedge clk);
    end
    n_chk++;
    if (bad != 0) $display("FAIL stop hold: got %0d active cycles want 0", bad);
    else n_pass++;
    start(32'hD000_0000);
    n_chk++;
    if (outs !== F0) $display("FAIL stop restart: got %h want %h", outs, F0);
    else n_pass++;
  endtask

  initial begin
    test_reset;
    test_add;
    test_ld_clr;
    test_st;
    test_br(1'b0);
    test_br(1'b1);
    test_mul;
    test_div;
    test_back_to_back;
    test_undef;
    test_halt;
    test_stop;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
